main_memory: RTL and testbench

Block-granular backing store that answers the cache's down-hierarchy request port. It serves 64 blocks of 32 bits with a fixed, parameterised access latency. It sits directly below the L1 and completes one read (fill) or write (writeback) per handshake. It also works as the bench memory model for cache verification.

---
 rtl/main_memory_if.sv | 20 ++
 rtl/main_memory.sv | 116 +++++++++++
 tb/tb_main_memory.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_memory_if.sv
// Down-hierarchy request bus between the L1 cache (master) and the
// backing store (slave): one-cycle request strobe in, one-cycle ready out.
interface main_memory_if;
  logic        d_request;
  logic        d_we;
  logic [5:0]  d_addr;
  logic [31:0] d_din;
  logic        d_ready;
  logic [31:0] d_dout;

  modport master (
    output d_request, d_we, d_addr, d_din,
    input  d_ready, d_dout
  );

  modport slave (
    input  d_request, d_we, d_addr, d_din,
    output d_ready, d_dout
  );
endinterface

// File: rtl/main_memory.sv
// main_memory: 64 x 32-bit block backing store with a fixed access latency.
// A request is captured in IDLE, the block waits LATENCY cycles in BUSY and
// then performs the captured read or write while pulsing d_ready once.
// Optional feature macro: MAIN_MEMORY_STATS_EN adds saturating completed
// read/write counters (rd_count, wr_count).
module main_memory #(
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  main_memory_if.slave bus
`ifdef MAIN_MEMORY_STATS_EN
  ,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);

  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  state_t      state_next;
  logic        capture;
  logic        access;
  logic [3:0]  count;
  logic        cap_we;
  logic [5:0]  cap_addr;
  logic [31:0] cap_din;
  logic [31:0] mem [64];
  logic        ready_q;
  logic [31:0] dout_q;

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state plus the capture/access strobes; requests in BUSY are ignored.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_request) begin
          capture    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (count == 4'd0) begin
          access     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Latency counter and captured request fields; live inputs unused after capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 4'd0;
      cap_we   <= 1'b0;
      cap_addr <= 6'd0;
      cap_din  <= 32'd0;
    end else if (capture) begin
      count    <= LOAD;
      cap_we   <= bus.d_we;
      cap_addr <= bus.d_addr;
      cap_din  <= bus.d_din;
    end else if (state == BUSY && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  // Storage and response: each byte resets to its own byte address.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        mem[i] <= {i[5:0], 2'b11, i[5:0], 2'b10, i[5:0], 2'b01, i[5:0], 2'b00};
      end
      ready_q <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      ready_q <= access;
      if (access) begin
        if (cap_we) mem[cap_addr] <= cap_din;
        else        dout_q        <= mem[cap_addr];
      end
    end
  end

  assign bus.d_ready = ready_q;
  assign bus.d_dout  = dout_q;

`ifdef MAIN_MEMORY_STATS_EN
  // Completed-operation counters, saturating at all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (access) begin
      if (cap_we) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_main_memory.sv
// Testbench for main_memory: table of directed read/write vectors on a
// LATENCY=4 instance plus hand-written sequences for back-to-back, ignored
// requests, reset mid-access and a LATENCY=1 instance.
module tb_main_memory;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  main_memory_if bus4 ();
  main_memory_if bus1 ();

`ifdef MAIN_MEMORY_STATS_EN
  logic [15:0] rd4, wr4, rd1, wr1;
`endif

  main_memory #(.LATENCY(4)) dut4 (
    .clk(clk),
    .reset(reset),
    .bus(bus4)
`ifdef MAIN_MEMORY_STATS_EN
    ,
    .rd_count(rd4),
    .wr_count(wr4)
`endif
  );

  main_memory #(.LATENCY(1)) dut1 (
    .clk(clk),
    .reset(reset),
    .bus(bus1)
`ifdef MAIN_MEMORY_STATS_EN
    ,
    .rd_count(rd1),
    .wr_count(wr1)
`endif
  );

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[7];
  int   checks   = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic req, input logic we,
                               input logic [5:0] addr, input logic [31:0] din);
    if (sel) begin
      bus1.d_request = req;
      bus1.d_we      = we;
      bus1.d_addr    = addr;
      bus1.d_din     = din;
    end else begin
      bus4.d_request = req;
      bus4.d_we      = we;
      bus4.d_addr    = addr;
      bus4.d_din     = din;
    end
  endtask

  function automatic logic readyOf(input bit sel);
    return sel ? bus1.d_ready : bus4.d_ready;
  endfunction

  function automatic logic [31:0] doutOf(input bit sel);
    return sel ? bus1.d_dout : bus4.d_dout;
  endfunction

  // One full handshake; lat counts negedges from the cycle after acceptance.
  task automatic runOp(input bit sel, input logic we, input logic [5:0] addr,
                       input logic [31:0] din, output int lat,
                       output logic [31:0] dout, output bit single);
    @(negedge clk);
    applyStimulus(sel, 1'b1, we, addr, din);
    @(negedge clk);
    applyStimulus(sel, 1'b0, we, addr, din);
    lat    = -1;
    dout   = 'x;
    single = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (readyOf(sel)) begin
        lat  = k;
        dout = doutOf(sel);
        break;
      end
      @(negedge clk);
    end
    if (lat >= 0) begin
      @(negedge clk);
      single = !readyOf(sel);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int          lat;
    int          pulses;
    bit          single;
    bit          changed;
    logic [31:0] dout;

    vecs[0] = '{we: 1'b0, addr: 6'h01, din: 32'h0,         exp_dout: 32'h07060504};
    vecs[1] = '{we: 1'b0, addr: 6'h05, din: 32'h0,         exp_dout: 32'h17161514};
    vecs[2] = '{we: 1'b1, addr: 6'h01, din: 32'h11223344,  exp_dout: 32'h17161514};
    vecs[3] = '{we: 1'b0, addr: 6'h01, din: 32'h0,         exp_dout: 32'h11223344};
    vecs[4] = '{we: 1'b0, addr: 6'h20, din: 32'h0,         exp_dout: 32'h83828180};
    vecs[5] = '{we: 1'b0, addr: 6'h3E, din: 32'h0,         exp_dout: 32'hFBFAF9F8};
    vecs[6] = '{we: 1'b0, addr: 6'h3F, din: 32'h0,         exp_dout: 32'hDEADBEEF};

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset ready4", 32'(bus4.d_ready), 32'd0);
    checkOutput("reset dout4",  bus4.d_dout, 32'h0);
    checkOutput("reset ready1", 32'(bus1.d_ready), 32'd0);
    checkOutput("reset dout1",  bus1.d_dout, 32'h0);

    $display("[TB] write 3F then back-to-back read 3F");
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'h3F, 32'hDEADBEEF);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    lat = -1;
    changed = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus4.d_dout !== 32'h0) changed = 1'b1;
      if (bus4.d_ready) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    checkOutput("b2b write latency", 32'(lat), 32'd4);
    checkOutput("b2b dout held during write", 32'(changed), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h3F, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    lat = -1;
    dout = 'x;
    for (int k = 0; k < 40; k++) begin
      if (bus4.d_ready) begin
        lat  = k;
        dout = bus4.d_dout;
        break;
      end
      @(negedge clk);
    end
    checkOutput("b2b read latency", 32'(lat), 32'd4);
    checkOutput("b2b read data", dout, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("b2b ready single cycle", 32'(bus4.d_ready), 32'd0);

    $display("[TB] request while busy is ignored");
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h00, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h01, 32'hCAFEF00D);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'h01, 32'hCAFEF00D);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    pulses = 0;
    lat    = -1;
    dout   = 'x;
    for (int k = 2; k < 20; k++) begin
      if (bus4.d_ready) begin
        pulses++;
        if (lat < 0) begin
          lat  = k;
          dout = bus4.d_dout;
        end
      end
      @(negedge clk);
    end
    checkOutput("busy pulses", 32'(pulses), 32'd1);
    checkOutput("busy latency", 32'(lat), 32'd4);
    checkOutput("busy read data", dout, 32'h03020100);

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      runOp(1'b0, vecs[i].we, vecs[i].addr, vecs[i].din, lat, dout, single);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      checkOutput($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
      checkOutput($sformatf("vec%0d single", i), 32'(single), 32'd1);
    end

    $display("[TB] reset mid-access");
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'h10, 32'h12345678);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h3F, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 32'h0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus4.d_ready) pulses++;
      @(negedge clk);
    end
    checkOutput("abort no ready", 32'(pulses), 32'd0);
    checkOutput("abort dout reset", bus4.d_dout, 32'h0);
    runOp(1'b0, 1'b0, 6'h10, 32'h0, lat, dout, single);
    checkOutput("abort read 10", dout, 32'h43424140);
    runOp(1'b0, 1'b0, 6'h3F, 32'h0, lat, dout, single);
    checkOutput("abort read 3F", dout, 32'hFFFEFDFC);

    $display("[TB] LATENCY=1 alternating write/read");
    runOp(1'b1, 1'b1, 6'h2A, 32'hA5A5A5A5, lat, dout, single);
    checkOutput("lat1 write latency", 32'(lat), 32'd1);
    checkOutput("lat1 write dout", dout, 32'h0);
    checkOutput("lat1 write single", 32'(single), 32'd1);
    runOp(1'b1, 1'b0, 6'h2A, 32'h0, lat, dout, single);
    checkOutput("lat1 read latency", 32'(lat), 32'd1);
    checkOutput("lat1 read data", dout, 32'hA5A5A5A5);
    runOp(1'b1, 1'b1, 6'h2A, 32'h5A5A5A5A, lat, dout, single);
    checkOutput("lat1 write2 latency", 32'(lat), 32'd1);
    runOp(1'b1, 1'b0, 6'h2A, 32'h0, lat, dout, single);
    checkOutput("lat1 read2 data", dout, 32'h5A5A5A5A);

`ifdef MAIN_MEMORY_STATS_EN
    $display("[TB] statistics counters");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    runOp(1'b0, 1'b0, 6'h01, 32'h0, lat, dout, single);
    runOp(1'b0, 1'b1, 6'h02, 32'h1, lat, dout, single);
    runOp(1'b0, 1'b0, 6'h03, 32'h0, lat, dout, single);
    runOp(1'b0, 1'b1, 6'h04, 32'h2, lat, dout, single);
    runOp(1'b0, 1'b0, 6'h05, 32'h0, lat, dout, single);
    checkOutput("stats rd_count", 32'(rd4), 32'd3);
    checkOutput("stats wr_count", 32'(wr4), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("stats rd_count reset", 32'(rd4), 32'd0);
    checkOutput("stats wr_count reset", 32'(wr4), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
